// File: rtl/h264_nal_pkg.sv
// Shared types and constants for the Annex-B NAL framer: FSM state encoding,
// fixed byte sequences and the 10-bit FIFO entry layout.
package h264_nal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_AUD   = 3'd1,
        ST_SC    = 3'd2,
        ST_HDR   = 3'd3,
        ST_PAY   = 3'd4,
        ST_EPB   = 3'd5,
        ST_TRAIL = 3'd6,
        ST_END   = 3'd7
    } nal_state_t;

    // Element 0 is the first byte on the wire.
    localparam logic [0:3][7:0] START_CODE = {8'h00, 8'h00, 8'h00, 8'h01};
    localparam logic [0:5][7:0] AUD_BYTES  = {8'h00, 8'h00, 8'h00, 8'h01, 8'h09, 8'hF0};
    localparam logic [7:0]      EPB_BYTE   = 8'h03;

    typedef struct packed {
        logic       eos;
        logic       dv;
        logic [7:0] data;
    } nal_entry_t;

    function automatic logic [7:0] nal_hdr_byte(input logic [1:0] idc, input logic [4:0] typ);
        return {1'b0, idc, typ};
    endfunction

    // Run length of zero payload bytes, saturating at two.
    function automatic logic [1:0] zc_next(input logic [1:0] zc, input logic [7:0] b);
        if (b != 8'h00) return 2'd0;
        return (zc == 2'd2) ? 2'd2 : zc + 2'd1;
    endfunction

endpackage

// File: rtl/h264_nal_fifo.sv
// Show-ahead synchronous FIFO, DEPTH x 10 bits; a write when full is dropped
// unless a read frees a slot in the same cycle.
module h264_nal_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wr_en_i,
    input  logic [9:0] wr_data_i,
    input  logic       rd_en_i,
    output logic [9:0] rd_data_o,
    output logic       full_o,
    output logic       empty_o,
    output logic       afull_o,
    output logic       drop_o
);
    localparam int AW = $clog2(DEPTH);

    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_rd;
    logic          do_wr;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign afull_o   = (count_q >= (AW+1)'(DEPTH - 2));
    assign do_rd     = rd_en_i && !empty_o;
    assign do_wr     = wr_en_i && (!full_o || do_rd);
    assign drop_o    = wr_en_i && full_o && !do_rd;
    assign rd_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/h264_nal_framer.sv
// Annex-B NAL framer: start code, NAL header and emulation-prevention insertion.
// Define H264_NAL_AUD_EN to prefix every slice with an access-unit delimiter.
module h264_nal_framer
    import h264_nal_pkg::*;
#(
    parameter int         DEPTH     = 16,
    parameter logic [1:0] NALREFIDC = 2'd3,
    parameter logic [4:0] NALTYPE   = 5'd5
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       NEWSLICE,
    input  logic       STROBEI,
    input  logic [7:0] BYTEI,
    input  logic       DONEI,
    output logic       AFULL,
    output logic       OVERFLOW,
    output logic [7:0] BYTEO,
    output logic       STROBEO,
    input  logic       READYO,
    output logic       NALDONE
);
    nal_state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [1:0] zc_q, zc_d;
    logic       pending_q, pending_d;
    logic [7:0] byte_q, byte_d;
    logic       strobe_q, strobe_d;
    logic       naldone_q, naldone_d;
    logic       ovf_q;

    nal_entry_t wr_entry, head;
    logic [9:0] head_bits;
    logic       fifo_wr, fifo_rd, fifo_empty, fifo_drop, unused_fifo_full;
    logic       out_free, load;
    logic [7:0] emit;

    assign fifo_wr  = STROBEI | DONEI;
    assign wr_entry = '{eos: DONEI, dv: STROBEI, data: (STROBEI ? BYTEI : 8'h00)};
    assign head     = nal_entry_t'(head_bits);

    h264_nal_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .wr_en_i   (fifo_wr),
        .wr_data_i (wr_entry),
        .rd_en_i   (fifo_rd),
        .rd_data_o (head_bits),
        .full_o    (unused_fifo_full),
        .empty_o   (fifo_empty),
        .afull_o   (AFULL),
        .drop_o    (fifo_drop)
    );

    // The output register can take a new byte when empty or being accepted now.
    assign out_free = !strobe_q || READYO;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        zc_d      = zc_q;
        pending_d = pending_q | NEWSLICE;
        naldone_d = 1'b0;
        fifo_rd   = 1'b0;
        load      = 1'b0;
        emit      = 8'h00;
        case (state_q)
            ST_IDLE: if (pending_q || NEWSLICE) begin
                cnt_d = 3'd0;
`ifdef H264_NAL_AUD_EN
                state_d = ST_AUD;
`else
                state_d   = ST_SC;
                pending_d = 1'b0;
`endif
            end
`ifdef H264_NAL_AUD_EN
            ST_AUD: if (out_free) begin
                load = 1'b1;
                emit = AUD_BYTES[cnt_q];
                if (cnt_q == 3'd5) begin
                    state_d   = ST_SC;
                    cnt_d     = 3'd0;
                    pending_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
`endif
            ST_SC: if (out_free) begin
                load = 1'b1;
                emit = START_CODE[cnt_q[1:0]];
                if (cnt_q[1:0] == 2'd3) state_d = ST_HDR;
                else cnt_d = cnt_q + 3'd1;
            end
            ST_HDR: if (out_free) begin
                load    = 1'b1;
                emit    = nal_hdr_byte(NALREFIDC, NALTYPE);
                zc_d    = 2'd0;
                state_d = ST_PAY;
            end
            // The escaped byte stays at the FIFO head until EPB emits it.
            ST_PAY: if (out_free && !fifo_empty) begin
                if (head.dv && zc_q == 2'd2 && head.data <= 8'h03) begin
                    load    = 1'b1;
                    emit    = EPB_BYTE;
                    zc_d    = 2'd0;
                    state_d = ST_EPB;
                end else if (head.dv) begin
                    load    = 1'b1;
                    emit    = head.data;
                    fifo_rd = 1'b1;
                    zc_d    = zc_next(zc_q, head.data);
                    if (head.eos) state_d = (head.data == 8'h00) ? ST_TRAIL : ST_END;
                end else begin
                    fifo_rd = 1'b1;
                    state_d = (zc_q != 2'd0) ? ST_TRAIL : ST_END;
                end
            end
            ST_EPB: if (out_free) begin
                load    = 1'b1;
                emit    = head.data;
                fifo_rd = 1'b1;
                zc_d    = (head.data == 8'h00) ? 2'd1 : 2'd0;
                if (head.eos) state_d = (head.data == 8'h00) ? ST_TRAIL : ST_END;
                else state_d = ST_PAY;
            end
            ST_TRAIL: if (out_free) begin
                load    = 1'b1;
                emit    = EPB_BYTE;
                state_d = ST_END;
            end
            ST_END: if (out_free) begin
                naldone_d = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_d   = byte_q;
        strobe_d = strobe_q;
        if (load) begin
            byte_d   = emit;
            strobe_d = 1'b1;
        end else if (out_free) begin
            strobe_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            zc_q      <= 2'd0;
            pending_q <= 1'b0;
            byte_q    <= 8'h00;
            strobe_q  <= 1'b0;
            naldone_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            zc_q      <= zc_d;
            pending_q <= pending_d;
            byte_q    <= byte_d;
            strobe_q  <= strobe_d;
            naldone_q <= naldone_d;
            ovf_q     <= ovf_q | fifo_drop;
        end
    end

    assign BYTEO    = byte_q;
    assign STROBEO  = strobe_q;
    assign NALDONE  = naldone_q;
    assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_h264_nal_framer.sv
// Bench for h264_nal_framer; expected header includes the AUD when H264_NAL_AUD_EN is defined.
module tb_h264_nal_framer;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       NEWSLICE = 1'b0;
    logic       STROBEI = 1'b0;
    logic [7:0] BYTEI = 8'h00;
    logic       DONEI = 1'b0;
    logic       READYO = 1'b1;
    logic       AFULL, OVERFLOW, STROBEO, NALDONE;
    logic [7:0] BYTEO;

    int checks = 0;
    int failures = 0;

    // Tokens: {1'b0, byte} for an accepted byte, 9'h100 for a NALDONE pulse.
    logic [8:0] exp_q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_byte = 8'h00;

    always #5 CLK = ~CLK;

    h264_nal_framer dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .NEWSLICE (NEWSLICE),
        .STROBEI  (STROBEI),
        .BYTEI    (BYTEI),
        .DONEI    (DONEI),
        .AFULL    (AFULL),
        .OVERFLOW (OVERFLOW),
        .BYTEO    (BYTEO),
        .STROBEO  (STROBEO),
        .READYO   (READYO),
        .NALDONE  (NALDONE)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge CLK) begin
        if (RESET) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_strobe", STROBEO, 1);
                check("hold_byte", BYTEO, prev_byte);
            end
            if (STROBEO && READYO) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_byte: got %02h expected nothing", BYTEO);
                end else begin
                    check("out_byte", {1'b0, BYTEO}, exp_q.pop_front());
                end
            end
            if (NALDONE) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_naldone: got pulse expected nothing");
                end else begin
                    check("naldone", 9'h100, exp_q.pop_front());
                end
            end
            prev_stall = STROBEO && !READYO;
            prev_byte  = BYTEO;
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic new_slice();
        NEWSLICE = 1'b1;
        tick();
        NEWSLICE = 1'b0;
    endtask

    task automatic put(input logic [7:0] b, input logic d);
        STROBEI = 1'b1;
        BYTEI   = b;
        DONEI   = d;
        tick();
        STROBEI = 1'b0;
        DONEI   = 1'b0;
        BYTEI   = 8'h00;
    endtask

    task automatic done_only();
        DONEI = 1'b1;
        tick();
        DONEI = 1'b0;
    endtask

    task automatic exp_b(input logic [7:0] b);
        exp_q.push_back({1'b0, b});
    endtask

    task automatic exp_done();
        exp_q.push_back(9'h100);
    endtask

    task automatic exp_hdr();
`ifdef H264_NAL_AUD_EN
        exp_b(8'h00); exp_b(8'h00); exp_b(8'h00); exp_b(8'h01); exp_b(8'h09); exp_b(8'hF0);
`endif
        exp_b(8'h00); exp_b(8'h00); exp_b(8'h00); exp_b(8'h01); exp_b(8'h65);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        check({"drain_", name}, exp_q.size(), 0);
        exp_q.delete();
        repeat (2) tick();
    endtask

    initial begin
        #1 RESET = 1'b1;
        #1;
        check("rst_byteo", BYTEO, 0);
        check("rst_strobeo", STROBEO, 0);
        check("rst_naldone", NALDONE, 0);
        check("rst_afull", AFULL, 0);
        check("rst_overflow", OVERFLOW, 0);
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        tick();

        // Basic slice: 11 22 then a standalone DONEI
        exp_hdr(); exp_b(8'h11); exp_b(8'h22); exp_done();
        new_slice();
        put(8'h11, 1'b0);
        put(8'h22, 1'b0);
        done_only();
        drain("basic");

        // 00 00 01 -> 00 00 03 01
        exp_hdr(); exp_b(8'h00); exp_b(8'h00); exp_b(8'h03); exp_b(8'h01); exp_done();
        new_slice();
        put(8'h00, 1'b0);
        put(8'h00, 1'b0);
        put(8'h01, 1'b1);
        drain("epb_01");

        // 00 00 04 passes unchanged
        exp_hdr(); exp_b(8'h00); exp_b(8'h00); exp_b(8'h04); exp_done();
        new_slice();
        put(8'h00, 1'b0);
        put(8'h00, 1'b0);
        put(8'h04, 1'b1);
        drain("no_epb_04");

        // 00 00 00 00 with DONEI on the last byte -> 00 00 03 00 00 03
        exp_hdr();
        exp_b(8'h00); exp_b(8'h00); exp_b(8'h03); exp_b(8'h00); exp_b(8'h00); exp_b(8'h03);
        exp_done();
        new_slice();
        put(8'h00, 1'b0);
        put(8'h00, 1'b0);
        put(8'h00, 1'b0);
        put(8'h00, 1'b1);
        drain("trail");

        // Output stall for three cycles mid-payload
        exp_hdr();
        for (int i = 0; i < 6; i++) exp_b(8'hA1 + 8'(i));
        exp_done();
        new_slice();
        for (int i = 0; i < 6; i++) put(8'hA1 + 8'(i), (i == 5));
        tick();
        READYO = 1'b0;
        repeat (3) tick();
        READYO = 1'b1;
        drain("stall");

        // Fill while IDLE with output blocked: AFULL from 14th write, OVERFLOW on 17th
        READYO = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            put(8'h40 + 8'(k - 1), 1'b0);
            check($sformatf("afull_w%0d", k), AFULL, (k >= 14));
            check($sformatf("overflow_w%0d", k), OVERFLOW, (k == 17));
        end
        exp_hdr();
        for (int i = 0; i < 16; i++) exp_b(8'h40 + 8'(i));
        exp_done();
        READYO = 1'b1;
        new_slice();
        repeat (12) tick();
        done_only();
        drain("overflow");
        check("overflow_sticky", OVERFLOW, 1);

        // Reset in the middle of a payload
        exp_hdr();
        for (int i = 0; i < 8; i++) exp_b(8'h61 + 8'(i));
        new_slice();
        for (int i = 0; i < 8; i++) put(8'h61 + 8'(i), 1'b0);
        #1 RESET = 1'b1;
        #1;
        check("midrst_byteo", BYTEO, 0);
        check("midrst_strobeo", STROBEO, 0);
        check("midrst_naldone", NALDONE, 0);
        check("midrst_afull", AFULL, 0);
        check("midrst_overflow", OVERFLOW, 0);
        exp_q.delete();
        @(posedge CLK);
        #1 RESET = 1'b0;
        tick();

        // Clean restart after reset
        exp_hdr(); exp_b(8'h77); exp_done();
        new_slice();
        put(8'h77, 1'b1);
        drain("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
